// File: rtl/sq_fetch_scheduler_if.sv
// DataMover MM2S command/status channels between the send-queue fetch scheduler
// (master) and the DataMover (slave).
interface sq_fetch_scheduler_if #(
   parameter int NUM_QUEUES = 4,
   parameter int ADDR_W     = 32
);
   localparam int QW = (NUM_QUEUES > 1) ? $clog2(NUM_QUEUES) : 1;

   // Command channel: a beat transfers on a rising clk edge where cmd_valid and
   // cmd_ready are both high; once raised, cmd_valid and its fields hold until then.
   // Status channel: sts_valid is a single-cycle pulse with no back-pressure.
   logic              cmd_valid;
   logic              cmd_ready;
   logic [ADDR_W-1:0] cmd_addr;
   logic [15:0]       cmd_btt;
   logic [QW-1:0]     cmd_tag;
   logic              sts_valid;
   logic [QW-1:0]     sts_tag;
   logic              sts_okay;

   modport master (
      output cmd_valid, cmd_addr, cmd_btt, cmd_tag,
      input  cmd_ready, sts_valid, sts_tag, sts_okay
   );

   modport slave (
      input  cmd_valid, cmd_addr, cmd_btt, cmd_tag,
      output cmd_ready, sts_valid, sts_tag, sts_okay
   );
endinterface

// File: rtl/sq_fetch_scheduler.sv
// Multi-queue RDMA send-queue WQE fetch engine: round-robin issue of one MM2S read
// command per pending WQE, retirement of WQEs on DataMover status.
module sq_fetch_scheduler #(
   parameter int NUM_QUEUES      = 4,
   parameter int IDX_W           = 8,
   parameter int ADDR_W          = 32,
   parameter int WQE_BYTES       = 64,
   parameter int MAX_OUTSTANDING = 2
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         global_enable,
   input  logic [NUM_QUEUES-1:0]        q_enable,
   input  logic [NUM_QUEUES*ADDR_W-1:0] sq_base_flat,
   input  logic [NUM_QUEUES*IDX_W-1:0]  sq_size_flat,
   input  logic [NUM_QUEUES*IDX_W-1:0]  sq_tail_flat,
   output logic [NUM_QUEUES*IDX_W-1:0]  sq_head_flat,
   sq_fetch_scheduler_if.master         dm,
   output logic [NUM_QUEUES-1:0]        q_err,
   output logic                         spurious_sts,
   output logic [3:0]                   outstanding,
   output logic [31:0]                  wqe_issued_cnt,
   output logic [31:0]                  wqe_done_cnt,
   output logic [1:0]                   fsm_state_dbg
);
   localparam int QW     = (NUM_QUEUES > 1) ? $clog2(NUM_QUEUES) : 1;
   localparam int WQE_SH = $clog2(WQE_BYTES);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ARB   = 2'd1,
      ST_ISSUE = 2'd2
   } state_e;

   state_e              state_q, state_d;
   logic [QW-1:0]       rr_q, rr_d;
   logic [QW-1:0]       tag_q, tag_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic                valid_q, valid_d;
   logic [NUM_QUEUES-1:0] q_err_q, q_err_d;
   logic                spurious_q, spurious_d;
   logic [3:0]          out_q, out_d;
   logic [31:0]         issued_q, issued_d;
   logic [31:0]         done_q, done_d;
   logic [IDX_W-1:0]    head_q [NUM_QUEUES];
   logic [IDX_W-1:0]    head_d [NUM_QUEUES];
   logic [IDX_W-1:0]    fptr_q [NUM_QUEUES];
   logic [IDX_W-1:0]    fptr_d [NUM_QUEUES];
   logic [3:0]          qcnt_q [NUM_QUEUES];
   logic [3:0]          qcnt_d [NUM_QUEUES];

   logic [NUM_QUEUES-1:0] elig;
   logic [NUM_QUEUES-1:0] tail_bad;
   logic                  any_elig;
   logic                  grant_found;
   logic [QW-1:0]         grant_idx;
   logic                  issue_hs;
   logic                  sts_hit;

   function automatic logic [IDX_W-1:0] ptr_inc(input logic [IDX_W-1:0] p,
                                                input logic [IDX_W-1:0] sz);
      logic [IDX_W:0] nxt;
      nxt = {1'b0, p} + {{IDX_W{1'b0}}, 1'b1};
      return (nxt == {1'b0, sz}) ? '0 : nxt[IDX_W-1:0];
   endfunction

   assign issue_hs = valid_q & dm.cmd_ready;
   assign sts_hit  = dm.sts_valid && (out_q != 4'd0) && (int'(dm.sts_tag) < NUM_QUEUES);

   // Tail is sampled live; an out-of-range tail halts the queue through q_err.
   always_comb begin
      logic [IDX_W-1:0] sz;
      logic [IDX_W-1:0] tl;
      elig     = '0;
      tail_bad = '0;
      for (int q = 0; q < NUM_QUEUES; q++) begin
         sz          = sq_size_flat[q*IDX_W +: IDX_W];
         tl          = sq_tail_flat[q*IDX_W +: IDX_W];
         tail_bad[q] = (sz != '0) && (tl >= sz);
         elig[q]     = global_enable && q_enable[q] && !q_err_q[q] && (sz != '0) &&
                       !tail_bad[q] && (fptr_q[q] != tl) &&
                       (out_q < 4'(MAX_OUTSTANDING));
      end
   end

   assign any_elig = |elig;

   always_comb begin
      int            idx;
      logic [QW-1:0] idx_w;
      grant_found = 1'b0;
      grant_idx   = '0;
      for (int i = 0; i < NUM_QUEUES; i++) begin
         idx = int'(rr_q) + i;
         if (idx >= NUM_QUEUES) idx = idx - NUM_QUEUES;
         idx_w = QW'(idx);
         if (!grant_found && elig[idx_w]) begin
            grant_found = 1'b1;
            grant_idx   = idx_w;
         end
      end
   end

   always_comb begin
      logic [IDX_W-1:0] sz;
      state_d    = state_q;
      rr_d       = rr_q;
      tag_d      = tag_q;
      addr_d     = addr_q;
      valid_d    = valid_q;
      q_err_d    = q_err_q;
      spurious_d = spurious_q | (dm.sts_valid & ~sts_hit);
      out_d      = out_q + 4'(issue_hs) - 4'(sts_hit);
      issued_d   = issued_q + 32'(issue_hs);
      done_d     = done_q + 32'(sts_hit);
      head_d     = head_q;
      fptr_d     = fptr_q;
      qcnt_d     = qcnt_q;

      case (state_q)
         ST_IDLE: begin
            if (any_elig) state_d = ST_ARB;
         end
         ST_ARB: begin
            if (grant_found) begin
               addr_d  = sq_base_flat[int'(grant_idx)*ADDR_W +: ADDR_W] +
                         (ADDR_W'(fptr_q[grant_idx]) << WQE_SH);
               tag_d   = grant_idx;
               valid_d = 1'b1;
               state_d = ST_ISSUE;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_ISSUE: begin
            if (issue_hs) begin
               valid_d = 1'b0;
               state_d = ST_IDLE;
               rr_d    = (int'(tag_q) == NUM_QUEUES - 1) ? '0 : tag_q + 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      for (int q = 0; q < NUM_QUEUES; q++) begin
         sz = sq_size_flat[q*IDX_W +: IDX_W];
         if (issue_hs && int'(tag_q) == q) begin
            fptr_d[q] = ptr_inc(fptr_q[q], sz);
            qcnt_d[q] = qcnt_q[q] + 4'd1;
         end
         if (sts_hit && int'(dm.sts_tag) == q) begin
            head_d[q] = ptr_inc(head_q[q], sz);
            if (qcnt_d[q] != 4'd0) qcnt_d[q] = qcnt_d[q] - 4'd1;
            if (!dm.sts_okay) q_err_d[q] = 1'b1;
         end
         if (tail_bad[q]) q_err_d[q] = 1'b1;
         // A disabled queue rewinds its fetch pointer once nothing of it is in flight,
         // including a command still parked on the command channel.
         if (!q_enable[q]) begin
            q_err_d[q] = 1'b0;
            if (qcnt_d[q] == 4'd0 && !(valid_q && int'(tag_q) == q))
               fptr_d[q] = head_d[q];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         rr_q       <= '0;
         tag_q      <= '0;
         addr_q     <= '0;
         valid_q    <= 1'b0;
         q_err_q    <= '0;
         spurious_q <= 1'b0;
         out_q      <= '0;
         issued_q   <= '0;
         done_q     <= '0;
         for (int q = 0; q < NUM_QUEUES; q++) begin
            head_q[q] <= '0;
            fptr_q[q] <= '0;
            qcnt_q[q] <= '0;
         end
      end else begin
         state_q    <= state_d;
         rr_q       <= rr_d;
         tag_q      <= tag_d;
         addr_q     <= addr_d;
         valid_q    <= valid_d;
         q_err_q    <= q_err_d;
         spurious_q <= spurious_d;
         out_q      <= out_d;
         issued_q   <= issued_d;
         done_q     <= done_d;
         for (int q = 0; q < NUM_QUEUES; q++) begin
            head_q[q] <= head_d[q];
            fptr_q[q] <= fptr_d[q];
            qcnt_q[q] <= qcnt_d[q];
         end
      end
   end

   always_comb begin
      sq_head_flat = '0;
      for (int q = 0; q < NUM_QUEUES; q++)
         sq_head_flat[q*IDX_W +: IDX_W] = head_q[q];
   end

   assign dm.cmd_valid     = valid_q;
   assign dm.cmd_addr      = addr_q;
   assign dm.cmd_btt       = 16'(WQE_BYTES);
   assign dm.cmd_tag       = tag_q;
   assign q_err            = q_err_q;
   assign spurious_sts     = spurious_q;
   assign outstanding      = out_q;
   assign wqe_issued_cnt   = issued_q;
   assign wqe_done_cnt     = done_q;
   assign fsm_state_dbg    = state_q;
endmodule

// File: tb/tb_sq_fetch_scheduler.sv
// Self-checking bench for sq_fetch_scheduler: directed vector table, hand-written
// corner sequences, and randomized rounds against a round-robin transaction model.
module tb_sq_fetch_scheduler;
   localparam int NQ     = 4;
   localparam int IDX_W  = 8;
   localparam int ADDR_W = 32;
   localparam int WQE    = 64;
   localparam int MAXO   = 2;
   localparam int QW     = 2;

   logic                    clk = 1'b0;
   logic                    rst_n;
   logic                    global_enable;
   logic [NQ-1:0]           q_enable;
   logic [NQ*ADDR_W-1:0]    sq_base_flat;
   logic [NQ*IDX_W-1:0]     sq_size_flat;
   logic [NQ*IDX_W-1:0]     sq_tail_flat;
   logic [NQ*IDX_W-1:0]     sq_head_flat;
   logic [NQ-1:0]           q_err;
   logic                    spurious_sts;
   logic [3:0]              outstanding;
   logic [31:0]             wqe_issued_cnt;
   logic [31:0]             wqe_done_cnt;
   logic [1:0]              fsm_state_dbg;

   sq_fetch_scheduler_if #(.NUM_QUEUES(NQ), .ADDR_W(ADDR_W)) dm_if ();

   sq_fetch_scheduler #(
      .NUM_QUEUES(NQ), .IDX_W(IDX_W), .ADDR_W(ADDR_W),
      .WQE_BYTES(WQE), .MAX_OUTSTANDING(MAXO)
   ) dut (
      .clk(clk), .rst_n(rst_n), .global_enable(global_enable), .q_enable(q_enable),
      .sq_base_flat(sq_base_flat), .sq_size_flat(sq_size_flat),
      .sq_tail_flat(sq_tail_flat), .sq_head_flat(sq_head_flat), .dm(dm_if),
      .q_err(q_err), .spurious_sts(spurious_sts), .outstanding(outstanding),
      .wqe_issued_cnt(wqe_issued_cnt), .wqe_done_cnt(wqe_done_cnt),
      .fsm_state_dbg(fsm_state_dbg)
   );

   // clock / reset
   always #5 clk = ~clk;

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   int checks = 0;
   int errors = 0;

   // command monitor: a beat seen at negedge transfers on the following posedge
   logic [QW+ADDR_W-1:0] obs_q[$];
   logic [QW+ADDR_W-1:0] exp_q[$];

   always @(negedge clk)
      if (rst_n && dm_if.cmd_valid && dm_if.cmd_ready)
         obs_q.push_back({dm_if.cmd_tag, dm_if.cmd_addr});

   task automatic check(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick(int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   function automatic logic [IDX_W-1:0] head_of(int q);
      return sq_head_flat[q*IDX_W +: IDX_W];
   endfunction

   // driver tasks
   task automatic set_q(int q, logic [ADDR_W-1:0] base, logic [IDX_W-1:0] size);
      sq_base_flat[q*ADDR_W +: ADDR_W] = base;
      sq_size_flat[q*IDX_W +: IDX_W]   = size;
   endtask

   task automatic set_tail(int q, logic [IDX_W-1:0] t);
      sq_tail_flat[q*IDX_W +: IDX_W] = t;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      global_enable = 1'b0;
      q_enable = '0;
      sq_base_flat = '0;
      sq_size_flat = '0;
      sq_tail_flat = '0;
      dm_if.cmd_ready = 1'b1;
      dm_if.sts_valid = 1'b0;
      dm_if.sts_tag = '0;
      dm_if.sts_okay = 1'b1;
      tick(3);
      rst_n = 1'b1;
      tick(1);
      obs_q.delete();
      exp_q.delete();
   endtask

   task automatic send_sts(int tag, logic okay);
      dm_if.sts_valid = 1'b1;
      dm_if.sts_tag   = QW'(tag);
      dm_if.sts_okay  = okay;
      tick(1);
      dm_if.sts_valid = 1'b0;
      dm_if.sts_okay  = 1'b1;
   endtask

   task automatic wait_obs(string name, int n, int budget);
      int c;
      c = 0;
      while (obs_q.size() < n && c < budget) begin
         tick(1);
         c++;
      end
      check({name, " cmd count"}, obs_q.size(), n);
   endtask

   task automatic pop_cmd(string name, int exp_tag, logic [ADDR_W-1:0] exp_addr);
      logic [QW+ADDR_W-1:0] v;
      if (obs_q.size() == 0) begin
         check({name, " present"}, obs_q.size(), 1);
      end else begin
         v = obs_q.pop_front();
         check({name, " tag"}, v[ADDR_W +: QW], exp_tag);
         check({name, " addr"}, v[ADDR_W-1:0], exp_addr);
      end
   endtask

   typedef struct {
      int               q;
      logic [ADDR_W-1:0] base;
      logic [IDX_W-1:0]  size;
      int               n;
      logic [ADDR_W-1:0] exp_last_addr;
      logic [IDX_W-1:0]  exp_head;
   } vec_t;

   vec_t vecs[5];

   // random-phase model state
   int m_size[NQ];
   int m_base[NQ];
   int m_fptr[NQ];
   int pend[NQ];
   int m_rr;
   int m_total;
   int inflight[$];

   initial begin
      int remaining;
      int pick;
      int c;
      int cyc;
      logic [QW+ADDR_W-1:0] v;
      logic [QW+ADDR_W-1:0] e;

      vecs[0] = '{0, 32'h1000_0000, 8'd8,   1, 32'h1000_0000, 8'd1};
      vecs[1] = '{1, 32'h2000_0040, 8'd4,   3, 32'h2000_00C0, 8'd3};
      vecs[2] = '{3, 32'hFFFF_FFC0, 8'd16,  2, 32'h0000_0000, 8'd2};
      vecs[3] = '{2, 32'h0000_0100, 8'd255, 5, 32'h0000_0200, 8'd5};
      vecs[4] = '{0, 32'h3000_0000, 8'd2,   1, 32'h3000_0000, 8'd1};

      // reset state
      do_reset();
      check("rst cmd_valid", dm_if.cmd_valid, 0);
      check("rst cmd_addr", dm_if.cmd_addr, 0);
      check("rst cmd_tag", dm_if.cmd_tag, 0);
      check("rst cmd_btt", dm_if.cmd_btt, WQE);
      check("rst heads", sq_head_flat, 0);
      check("rst q_err", q_err, 0);
      check("rst spurious", spurious_sts, 0);
      check("rst outstanding", outstanding, 0);
      check("rst issued", wqe_issued_cnt, 0);
      check("rst done", wqe_done_cnt, 0);
      check("rst fsm idle", fsm_state_dbg, 0);

      // vector table: single queue, n WQEs retired one at a time
      foreach (vecs[i]) begin
         do_reset();
         set_q(vecs[i].q, vecs[i].base, vecs[i].size);
         set_tail(vecs[i].q, IDX_W'(vecs[i].n));
         q_enable = NQ'(1 << vecs[i].q);
         global_enable = 1'b1;
         for (int k = 0; k < vecs[i].n; k++) begin
            wait_obs($sformatf("vec%0d.%0d", i, k), 1, 20);
            if (k == vecs[i].n - 1)
               pop_cmd($sformatf("vec%0d last", i), vecs[i].q, vecs[i].exp_last_addr);
            else if (obs_q.size() > 0)
               v = obs_q.pop_front();
            send_sts(vecs[i].q, 1'b1);
         end
         tick(2);
         check($sformatf("vec%0d head", i), head_of(vecs[i].q), vecs[i].exp_head);
         check($sformatf("vec%0d issued", i), wqe_issued_cnt, vecs[i].n);
         check($sformatf("vec%0d done", i), wqe_done_cnt, vecs[i].n);
         check($sformatf("vec%0d outstanding", i), outstanding, 0);
      end

      // outstanding cap across four queues
      do_reset();
      for (int q = 0; q < NQ; q++) begin
         set_q(q, 32'h4000_0000 + 32'(q) * 32'h1000, 8'd8);
         set_tail(q, 8'd1);
      end
      q_enable = '1;
      global_enable = 1'b1;
      wait_obs("cap first", 2, 40);
      tick(20);
      check("cap stall count", obs_q.size(), 2);
      check("cap outstanding", outstanding, 2);
      pop_cmd("cap c0", 0, 32'h4000_0000);
      pop_cmd("cap c1", 1, 32'h4000_1000);
      send_sts(0, 1'b1);
      send_sts(1, 1'b1);
      wait_obs("cap second", 2, 40);
      pop_cmd("cap c2", 2, 32'h4000_2000);
      pop_cmd("cap c3", 3, 32'h4000_3000);
      send_sts(2, 1'b1);
      send_sts(3, 1'b1);
      tick(2);
      check("cap done", wqe_done_cnt, 4);
      check("cap outstanding end", outstanding, 0);

      // pointer wrap on a size-4 queue
      do_reset();
      set_q(1, 32'h5000_0000, 8'd4);
      set_tail(1, 8'd3);
      q_enable = 4'b0010;
      global_enable = 1'b1;
      for (int k = 0; k < 3; k++) begin
         wait_obs($sformatf("wrap pre%0d", k), 1, 20);
         pop_cmd($sformatf("wrap pre%0d", k), 1, 32'h5000_0000 + 32'(k) * 32'h40);
         send_sts(1, 1'b1);
      end
      tick(1);
      check("wrap head3", head_of(1), 3);
      set_tail(1, 8'd1);
      wait_obs("wrap pair", 2, 40);
      pop_cmd("wrap c3", 1, 32'h5000_00C0);
      pop_cmd("wrap c0", 1, 32'h5000_0000);
      send_sts(1, 1'b1);
      send_sts(1, 1'b1);
      tick(1);
      check("wrap head1", head_of(1), 1);

      // back-pressure and enable drop while a command is parked
      do_reset();
      set_q(0, 32'h6000_0000, 8'd8);
      dm_if.cmd_ready = 1'b0;
      set_tail(0, 8'd1);
      q_enable = 4'b0001;
      global_enable = 1'b1;
      c = 0;
      while (!dm_if.cmd_valid && c < 20) begin
         tick(1);
         c++;
      end
      check("bp valid up", dm_if.cmd_valid, 1);
      global_enable = 1'b0;
      for (int k = 0; k < 10; k++) begin
         tick(1);
         check("bp valid hold", dm_if.cmd_valid, 1);
         check("bp addr hold", dm_if.cmd_addr, 32'h6000_0000);
         check("bp tag hold", dm_if.cmd_tag, 0);
      end
      dm_if.cmd_ready = 1'b1;
      wait_obs("bp accept", 1, 5);
      pop_cmd("bp cmd", 0, 32'h6000_0000);
      tick(1);
      check("bp valid down", dm_if.cmd_valid, 0);
      check("bp issued", wqe_issued_cnt, 1);

      // error status halts a queue; disable/enable clears it
      do_reset();
      set_q(2, 32'h7000_0000, 8'd8);
      set_tail(2, 8'd1);
      q_enable = 4'b0100;
      global_enable = 1'b1;
      wait_obs("err first", 1, 20);
      pop_cmd("err first", 2, 32'h7000_0000);
      send_sts(2, 1'b0);
      tick(1);
      check("err sticky", q_err[2], 1);
      check("err head", head_of(2), 1);
      check("err outstanding", outstanding, 0);
      set_tail(2, 8'd2);
      tick(20);
      check("err halted", obs_q.size(), 0);
      check("err issued", wqe_issued_cnt, 1);
      q_enable = 4'b0000;
      tick(2);
      q_enable = 4'b0100;
      tick(1);
      check("err cleared", q_err[2], 0);
      wait_obs("err resume", 1, 20);
      pop_cmd("err resume", 2, 32'h7000_0040);
      send_sts(2, 1'b1);
      tick(1);
      check("err head2", head_of(2), 2);

      // spurious status and out-of-range tail
      do_reset();
      send_sts(0, 1'b1);
      tick(1);
      check("spur flag", spurious_sts, 1);
      check("spur head", head_of(0), 0);
      check("spur done", wqe_done_cnt, 0);
      check("spur outstanding", outstanding, 0);
      set_q(0, 32'h8000_0000, 8'd4);
      set_tail(0, 8'd4);
      q_enable = 4'b0001;
      global_enable = 1'b1;
      tick(5);
      check("tail oob err", q_err[0], 1);
      check("tail oob no issue", wqe_issued_cnt, 0);
      check("spur still set", spurious_sts, 1);

      // randomized rounds against the round-robin model
      do_reset();
      for (int q = 0; q < NQ; q++) begin
         m_size[q] = $urandom_range(2, 16);
         m_base[q] = int'($urandom & 32'hFFFF_FFC0);
         m_fptr[q] = 0;
         set_q(q, m_base[q], IDX_W'(m_size[q]));
      end
      m_rr = 0;
      m_total = 0;
      inflight.delete();
      q_enable = '1;
      global_enable = 1'b1;
      for (int r = 0; r < 6; r++) begin
         remaining = 0;
         for (int q = 0; q < NQ; q++) begin
            pend[q] = $urandom_range(0, m_size[q] - 1);
            remaining += pend[q];
            set_tail(q, IDX_W'((m_fptr[q] + pend[q]) % m_size[q]));
         end
         while (remaining > 0) begin
            pick = 0;
            for (int k = NQ - 1; k >= 0; k--)
               if (pend[(m_rr + k) % NQ] > 0) pick = (m_rr + k) % NQ;
            exp_q.push_back({QW'(pick), 32'(m_base[pick]) + 32'(m_fptr[pick] * WQE)});
            m_fptr[pick] = (m_fptr[pick] + 1) % m_size[pick];
            pend[pick]--;
            remaining--;
            m_rr = (pick + 1) % NQ;
            m_total++;
         end
         cyc = 0;
         while ((exp_q.size() > 0 || inflight.size() > 0 || obs_q.size() > 0) && cyc < 3000) begin
            dm_if.cmd_ready = ($urandom_range(0, 3) != 0);
            if (inflight.size() > 0 && $urandom_range(0, 2) == 0) begin
               dm_if.sts_valid = 1'b1;
               dm_if.sts_tag   = QW'(inflight.pop_front());
            end else begin
               dm_if.sts_valid = 1'b0;
            end
            tick(1);
            cyc++;
            while (obs_q.size() > 0) begin
               v = obs_q.pop_front();
               if (exp_q.size() == 0) begin
                  check("rand unexpected cmd", exp_q.size(), 1);
               end else begin
                  e = exp_q.pop_front();
                  check($sformatf("rand r%0d tag", r), v[ADDR_W +: QW], e[ADDR_W +: QW]);
                  check($sformatf("rand r%0d addr", r), v[ADDR_W-1:0], e[ADDR_W-1:0]);
               end
               inflight.push_back(int'(v[ADDR_W +: QW]));
            end
            check("rand outstanding", outstanding, inflight.size());
         end
         dm_if.sts_valid = 1'b0;
         dm_if.cmd_ready = 1'b1;
         tick(2);
         check($sformatf("rand r%0d drained", r), exp_q.size() + inflight.size(), 0);
         for (int q = 0; q < NQ; q++)
            check($sformatf("rand r%0d head%0d", r, q), head_of(q), m_fptr[q]);
         check($sformatf("rand r%0d issued", r), wqe_issued_cnt, m_total);
         check($sformatf("rand r%0d done", r), wqe_done_cnt, m_total);
         check($sformatf("rand r%0d q_err", r), q_err, 0);
      end

      // final report
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
